fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage 16-bit pipeline.
- Keeps shadow copies of destination info for the EX, MEM and WB stages.
- Drives the 3-bit source selects of the two EX-operand forwarding muxes.
- Generates pipeline stall and EX-bubble controls for load-use hazards and for multi-cycle (mul/div) EX operations.

---
 rtl/fwd_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard controller for the 5-stage 16-bit pipeline.
// Tracks EX/MEM/WB destination shadows and generates stall/bubble/mux selects.
module fwd_hazard_ctrl #(
    parameter int RAW       = 4,
    parameter int HI_REG    = 0,
    parameter int MC_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           id_uses_rs,
    input  logic           id_uses_rt,
    input  logic [RAW-1:0] id_rd,
    input  logic           id_wr_lo,
    input  logic           id_wr_hi,
    input  logic           id_is_load,
    input  logic           id_is_mc,
    output logic           stall,
    output logic           ex_bubble,
    output logic [2:0]     src_a,
    output logic [2:0]     src_b,
    output logic           mc_busy,
    output logic           o_dbg_state
);

    localparam int CW = $clog2(MC_CYCLES) + 1;

    typedef enum logic {S_RUN = 1'b0, S_MC = 1'b1} state_t;

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic           uses_rs;
        logic           uses_rt;
        logic [RAW-1:0] rd;
        logic           wr_lo;
        logic           wr_hi;
        logic           is_load;
        logic           is_mc;
    } shadow_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    shadow_t         r_ex, r_mem, r_wb;
    shadow_t         w_ex_nxt, w_mem_nxt, w_wb_nxt;
    shadow_t         w_id;
    logic            w_load_use;
    logic            w_unused;

    // MEM holding a load never forwards: its data only exists from WB onward.
    function automatic logic [2:0] f_sel(input logic uses, input logic [RAW-1:0] src,
                                         input shadow_t ex, input shadow_t mem,
                                         input shadow_t wb);
        logic [2:0] sel;
        sel = 3'b000;
        if (uses && ex.valid) begin
            if (mem.valid && !mem.is_load && mem.wr_lo && mem.rd == src)
                sel = 3'b010;
            else if (mem.valid && !mem.is_load && mem.wr_hi && RAW'(HI_REG) == src)
                sel = 3'b001;
            else if (wb.valid && wb.wr_lo && wb.rd == src)
                sel = 3'b100;
            else if (wb.valid && wb.wr_hi && RAW'(HI_REG) == src)
                sel = 3'b011;
        end
        return sel;
    endfunction

    always_comb begin
        w_id.valid   = id_valid;
        w_id.rs      = id_rs;
        w_id.rt      = id_rt;
        w_id.uses_rs = id_uses_rs;
        w_id.uses_rt = id_uses_rt;
        w_id.rd      = id_rd;
        w_id.wr_lo   = id_wr_lo;
        w_id.wr_hi   = id_wr_hi;
        w_id.is_load = id_is_load;
        w_id.is_mc   = id_is_mc;
    end

    assign w_load_use = r_ex.valid && r_ex.is_load && r_ex.wr_lo && id_valid &&
                        ((id_uses_rs && id_rs == r_ex.rd) ||
                         (id_uses_rt && id_rt == r_ex.rd));

    // The mc op enters MC on the edge that moves it into EX, so its first
    // EX cycle already stalls; the release cycle (back in RUN) is the last.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ex_nxt    = r_ex;
        w_mem_nxt   = r_ex;
        w_wb_nxt    = r_mem;
        stall       = 1'b0;
        mc_busy     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_load_use) begin
                    stall    = 1'b1;
                    w_ex_nxt = '0;
                end else begin
                    w_ex_nxt = id_valid ? w_id : '0;
                    if (id_valid && id_is_mc) begin
                        w_state_nxt = S_MC;
                        w_cnt_nxt   = CW'(MC_CYCLES - 1);
                    end
                end
            end
            S_MC: begin
                stall     = 1'b1;
                mc_busy   = 1'b1;
                w_ex_nxt  = r_ex;
                w_mem_nxt = '0;
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1))
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ex    <= w_ex_nxt;
            r_mem   <= w_mem_nxt;
            r_wb    <= w_wb_nxt;
        end
    end

    assign src_a       = f_sel(r_ex.uses_rs, r_ex.rs, r_ex, r_mem, r_wb);
    assign src_b       = f_sel(r_ex.uses_rt, r_ex.rt, r_ex, r_mem, r_wb);
    assign ex_bubble   = !r_ex.valid;
    assign o_dbg_state = r_state;

    // Shadow fields kept for debug visibility but not consumed by any logic.
    assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: hand-computed selects, stalls and bubbles.
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [3:0] id_rd;
    logic       id_wr_lo;
    logic       id_wr_hi;
    logic       id_is_load;
    logic       id_is_mc;
    logic       stall;
    logic       ex_bubble;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic       mc_busy;
    logic       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_ctrl #(.RAW(4), .HI_REG(0), .MC_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_wr_lo    (id_wr_lo),
        .id_wr_hi    (id_wr_hi),
        .id_is_load  (id_is_load),
        .id_is_mc    (id_is_mc),
        .stall       (stall),
        .ex_bubble   (ex_bubble),
        .src_a       (src_a),
        .src_b       (src_b),
        .mc_busy     (mc_busy),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                          input logic urs, input logic urt, input logic [3:0] rd,
                          input logic wlo, input logic whi, input logic ld,
                          input logic mc);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_rd      = rd;
        id_wr_lo   = wlo;
        id_wr_hi   = whi;
        id_is_load = ld;
        id_is_mc   = mc;
    endtask

    task automatic nop();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ALU op writing lo half of rd
    task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        set_id(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        nop();
        tick();
        tick();
        tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        #2;
        chk("rst_stall", 8'(stall), 8'd0);
        chk("rst_bubble", 8'(ex_bubble), 8'd1);
        chk("rst_src_a", 8'(src_a), 8'd0);
        chk("rst_src_b", 8'(src_b), 8'd0);
        chk("rst_mc_busy", 8'(mc_busy), 8'd0);
        chk("rst_state", 8'(dbg_state), 8'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // back-to-back dependency
        alu(4'd3, 4'd1, 4'd2);
        tick();
        alu(4'd4, 4'd3, 4'd5);
        tick();
        set_id(1'b1, 4'd4, 4'd4, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("b2b_src_a", 8'(src_a), 8'b010);
        chk("b2b_src_b", 8'(src_b), 8'b000);
        chk("b2b_stall", 8'(stall), 8'd0);
        chk("b2b_bubble", 8'(ex_bubble), 8'd0);
        tick();
        chk("nouse_src_a", 8'(src_a), 8'b010);
        chk("nouse_src_b", 8'(src_b), 8'b000);
        flush();

        // two-apart dependency
        alu(4'd3, 4'd1, 4'd2);
        tick();
        nop();
        tick();
        alu(4'd6, 4'd3, 4'd3);
        tick();
        nop();
        chk("two_src_a", 8'(src_a), 8'b100);
        chk("two_src_b", 8'(src_b), 8'b100);
        flush();

        // same register in flight twice: MEM beats WB
        alu(4'd3, 4'd1, 4'd2);
        tick();
        alu(4'd3, 4'd1, 4'd2);
        tick();
        alu(4'd4, 4'd3, 4'd9);
        tick();
        nop();
        chk("young_src_a", 8'(src_a), 8'b010);
        chk("young_src_b", 8'(src_b), 8'b000);
        flush();

        // hi-half forward from MEM, then from WB
        set_id(1'b1, 4'd4, 4'd5, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        alu(4'd7, 4'd0, 4'd2);
        tick();
        nop();
        chk("hi_mem_src_a", 8'(src_a), 8'b001);
        chk("lo_mem_src_b", 8'(src_b), 8'b010);
        flush();
        set_id(1'b1, 4'd4, 4'd5, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        alu(4'd7, 4'd0, 4'd2);
        tick();
        nop();
        chk("hi_wb_src_a", 8'(src_a), 8'b011);
        chk("lo_wb_src_b", 8'(src_b), 8'b100);
        flush();

        // load whose result is not read: no stall
        set_id(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("ld_nouse_stall", 8'(stall), 8'd0);
        flush();

        // load-use: one stall cycle, one bubble, then forward from WB
        set_id(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        alu(4'd8, 4'd7, 4'd1);
        #1;
        chk("lu_stall", 8'(stall), 8'd1);
        chk("lu_bubble0", 8'(ex_bubble), 8'd0);
        tick();
        chk("lu_stall_end", 8'(stall), 8'd0);
        chk("lu_bubble1", 8'(ex_bubble), 8'd1);
        chk("lu_bub_src_a", 8'(src_a), 8'b000);
        tick();
        nop();
        #1;
        chk("lu_src_a", 8'(src_a), 8'b100);
        chk("lu_src_b", 8'(src_b), 8'b000);
        chk("lu_bubble2", 8'(ex_bubble), 8'd0);
        chk("lu_stall2", 8'(stall), 8'd0);
        flush();

        // multi-cycle op: DIV r5 = r3 / r5 after ADD r3
        alu(4'd3, 4'd1, 4'd2);
        tick();
        set_id(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        alu(4'd6, 4'd5, 4'd1);
        #1;
        chk("mc1_stall", 8'(stall), 8'd1);
        chk("mc1_busy", 8'(mc_busy), 8'd1);
        chk("mc1_state", 8'(dbg_state), 8'd1);
        chk("mc1_src_a", 8'(src_a), 8'b010);
        chk("mc1_src_b", 8'(src_b), 8'b000);
        tick();
        chk("mc2_stall", 8'(stall), 8'd1);
        chk("mc2_busy", 8'(mc_busy), 8'd1);
        chk("mc2_src_a", 8'(src_a), 8'b100);
        chk("mc2_src_b", 8'(src_b), 8'b000);
        tick();
        chk("mc3_stall", 8'(stall), 8'd1);
        chk("mc3_src_a", 8'(src_a), 8'b000);
        tick();
        chk("mc_rel_stall", 8'(stall), 8'd0);
        chk("mc_rel_busy", 8'(mc_busy), 8'd0);
        chk("mc_rel_bubble", 8'(ex_bubble), 8'd0);
        tick();
        nop();
        chk("mc_fol_src_a", 8'(src_a), 8'b010);
        chk("mc_fol_stall", 8'(stall), 8'd0);
        flush();

        // back-to-back mc ops
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 4'd5, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("bb_rel_stall", 8'(stall), 8'd0);
        tick();
        nop();
        #1;
        chk("bb_mc2_stall", 8'(stall), 8'd1);
        chk("bb_mc2_busy", 8'(mc_busy), 8'd1);
        chk("bb_mc2_src_a", 8'(src_a), 8'b010);
        tick();
        tick();
        tick();
        chk("bb_mc2_rel_busy", 8'(mc_busy), 8'd0);
        flush();

        // reset during MC cycle 2
        alu(4'd3, 4'd1, 4'd2);
        tick();
        set_id(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        nop();
        tick();
        chk("rmc_pre_stall", 8'(stall), 8'd1);
        chk("rmc_pre_src_a", 8'(src_a), 8'b100);
        rst_n = 1'b0;
        #1;
        chk("rmc_stall", 8'(stall), 8'd0);
        chk("rmc_src_a", 8'(src_a), 8'b000);
        chk("rmc_src_b", 8'(src_b), 8'b000);
        chk("rmc_bubble", 8'(ex_bubble), 8'd1);
        chk("rmc_busy", 8'(mc_busy), 8'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rmc_after_stall", 8'(stall), 8'd0);
        chk("rmc_after_bubble", 8'(ex_bubble), 8'd1);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
